// File: rtl/lfsr_crypt_seq.sv
// Stream cipher sequencer: reads config bytes, seeds an external 6-bit LFSR, writes a
// keystream-masked preamble followed by the XOR-encrypted message into data memory.
module lfsr_crypt_seq #(
  parameter int MSG_LEN  = 50,
  parameter int OUT_BASE = 64,
  parameter int CFG_BASE = 61
) (
  input  logic       clk,
  input  logic       init,
  input  logic       go,
  input  logic       abort,
  output logic [7:0] mem_raddr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic       lfsr_load,
  output logic       lfsr_en,
  output logic [5:0] lfsr_taps,
  output logic [5:0] lfsr_start,
  input  logic [5:0] lfsr_state,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, RD_PRE, RD_TAPS, RD_START, LOAD, PRE, MSG, FIN
  } state_t;

  localparam logic [7:0] CFG_A    = 8'(CFG_BASE);
  localparam logic [7:0] OUT_A    = 8'(OUT_BASE);
  localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pre_len_q, pre_len_d;
  logic [5:0] taps_q, taps_d;
  logic [5:0] start_q, start_d;
  logic       stop;

  function automatic logic [3:0] clamp_pre(input logic [7:0] v);
    if (v < 8'd7)       return 4'd7;
    else if (v > 8'd12) return 4'd12;
    else                return v[3:0];
  endfunction

  // An all-zero seed would lock the LFSR up, so it is promoted to 1.
  function automatic logic [5:0] fix_seed(input logic [5:0] v);
    return (v == 6'h00) ? 6'h01 : v;
  endfunction

  assign stop = abort && (state_q != IDLE) && (state_q != FIN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_len_d = pre_len_q;
    taps_d    = taps_q;
    start_d   = start_q;
    mem_raddr = 8'h00;
    mem_we    = 1'b0;
    mem_waddr = 8'h00;
    mem_wdata = 8'h00;
    lfsr_load = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'h00;
        if (go && !abort) state_d = RD_PRE;
      end
      RD_PRE: begin
        mem_raddr = CFG_A;
        pre_len_d = clamp_pre(mem_rdata);
        state_d   = RD_TAPS;
      end
      RD_TAPS: begin
        mem_raddr = CFG_A + 8'd1;
        taps_d    = mem_rdata[5:0];
        state_d   = RD_START;
      end
      RD_START: begin
        mem_raddr = CFG_A + 8'd2;
        start_d   = fix_seed(mem_rdata[5:0]);
        state_d   = LOAD;
      end
      LOAD: begin
        lfsr_load = 1'b1;
        cnt_d     = 8'h00;
        state_d   = PRE;
      end
      PRE: begin
        mem_we    = 1'b1;
        mem_waddr = OUT_A + cnt_q;
        mem_wdata = 8'h5F ^ {2'b00, lfsr_state};
        if (cnt_q == {4'b0000, pre_len_q} - 8'd1) begin
          cnt_d   = 8'h00;
          state_d = MSG;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MSG: begin
        mem_raddr = cnt_q;
        mem_we    = 1'b1;
        mem_waddr = OUT_A + {4'b0000, pre_len_q} + cnt_q;
        mem_wdata = mem_rdata ^ {2'b00, lfsr_state};
        if (cnt_q == MSG_LAST) begin
          cnt_d   = 8'h00;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Cancel: squash this cycle's side effects and leave config untouched.
    if (stop) begin
      state_d   = IDLE;
      cnt_d     = 8'h00;
      pre_len_d = pre_len_q;
      taps_d    = taps_q;
      start_d   = start_q;
      mem_we    = 1'b0;
      lfsr_load = 1'b0;
    end
  end

  assign lfsr_en    = mem_we;
  assign busy       = (state_q != IDLE);
  assign lfsr_taps  = taps_q;
  assign lfsr_start = start_q;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h00;
      pre_len_q <= 4'd7;
      taps_q    <= 6'h00;
      start_q   <= 6'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_len_q <= pre_len_d;
      taps_q    <= taps_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: tb/tb_lfsr_crypt_seq.sv
// Bench for lfsr_crypt_seq: models data memory and the external LFSR, predicts the output
// stream as keystream XOR (preamble constant, then message), and checks timing and aborts.
module tb_lfsr_crypt_seq;
  localparam int MSG_LEN  = 50;
  localparam int OUT_BASE = 64;
  localparam int CFG_BASE = 61;

  logic       clk = 1'b0;
  logic       init, go, abort, clr;
  logic [7:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic       mem_we, lfsr_load, lfsr_en, busy, done;
  logic [5:0] lfsr_taps, lfsr_start, lfsr_state, lfsr_q;

  logic [7:0] src     [256];
  logic [7:0] out_mem [256];
  logic [7:0] exp_mem [256];
  int checks = 0;
  int errors = 0;

  lfsr_crypt_seq #(.MSG_LEN(MSG_LEN), .OUT_BASE(OUT_BASE), .CFG_BASE(CFG_BASE)) dut (
    .clk(clk), .init(init), .go(go), .abort(abort),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .lfsr_taps(lfsr_taps),
    .lfsr_start(lfsr_start), .lfsr_state(lfsr_state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  assign mem_rdata  = src[mem_raddr];
  assign lfsr_state = lfsr_q;

  always @(posedge clk) begin
    if (lfsr_load)    lfsr_q <= lfsr_start;
    else if (lfsr_en) lfsr_q <= lfsr_step(lfsr_q, lfsr_taps);
    if (clr) begin
      for (int i = 0; i < 256; i++) out_mem[i] <= 8'hA5;
    end else if (mem_we) begin
      out_mem[mem_waddr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected memory image: nwr bytes of keystream-masked output from OUT_BASE upward.
  task automatic build_expect(input int p, input logic [5:0] taps, input logic [5:0] seed,
                              input int nwr);
    logic [5:0] s;
    s = seed;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'hA5;
    for (int i = 0; i < nwr; i++) begin
      exp_mem[OUT_BASE + i] = ((i < p) ? 8'h5F : src[i - p]) ^ {2'b00, s};
      s = lfsr_step(s, taps);
    end
  endtask

  task automatic run(input logic [7:0] pre_raw, input logic [7:0] taps_raw,
                     input logic [7:0] start_raw, input int abort_cyc,
                     input int go_busy_cyc, input int init_cyc, input string tag);
    int p, cyc, nwr, nload, nexp;
    logic [5:0] seed;
    bit got_done, stopped;
    p    = (pre_raw < 8'd7) ? 7 : ((pre_raw > 8'd12) ? 12 : int'(pre_raw));
    seed = (start_raw[5:0] == 6'h00) ? 6'h01 : start_raw[5:0];
    src[CFG_BASE]     = pre_raw;
    src[CFG_BASE + 1] = taps_raw;
    src[CFG_BASE + 2] = start_raw;
    for (int j = 0; j < MSG_LEN; j++) src[j] = 8'($urandom);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; go = 1'b1;
    cyc = 0; nwr = 0; nload = 0; got_done = 0; stopped = 0;
    while (!got_done && !stopped && cyc < 300) begin
      @(negedge clk);
      go = 1'b0;
      cyc++;
      if (cyc == go_busy_cyc) go = 1'b1;
      if (cyc == abort_cyc) abort = 1'b1;
      if (cyc == init_cyc) begin #2; init = 1'b1; end
      #1;
      if (cyc == abort_cyc) begin
        chk({tag, " abort_we"}, {62'b0, mem_we, lfsr_en}, 64'd0);
        chk({tag, " abort_load"}, {63'b0, lfsr_load}, 64'd0);
        stopped = 1;
      end else if (cyc == init_cyc) begin
        chk({tag, " init_outs"}, {mem_raddr, mem_we, mem_waddr, mem_wdata, lfsr_load, lfsr_en,
                                  lfsr_taps, lfsr_start, busy, done}, 64'd0);
        stopped = 1;
      end else begin
        chk({tag, " busy"}, {63'b0, busy}, 64'd1);
        chk({tag, " en_eq_we"}, {63'b0, lfsr_en}, {63'b0, mem_we});
        chk({tag, " we_load_excl"}, {63'b0, mem_we & lfsr_load}, 64'd0);
        if (lfsr_load) begin
          nload++;
          chk({tag, " load_cyc"}, 64'(cyc), 64'd4);
          chk({tag, " taps"}, {58'b0, lfsr_taps}, {58'b0, taps_raw[5:0]});
          chk({tag, " seed"}, {58'b0, lfsr_start}, {58'b0, seed});
        end
        if (mem_we) nwr++;
        if (done) begin
          got_done = 1;
          chk({tag, " done_cyc"}, 64'(cyc), 64'(5 + p + MSG_LEN));
          chk({tag, " fin_we"}, {63'b0, mem_we}, 64'd0);
        end
      end
    end
    if (!got_done && !stopped) chk({tag, " timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    go = 1'b0; abort = 1'b0; init = 1'b0;
    #1;
    chk({tag, " idle_busy"}, {63'b0, busy}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk({tag, " no_done"}, {63'b0, done}, 64'd0);
      @(negedge clk); #1;
    end
    if (abort_cyc > 0)     nexp = (abort_cyc > 5) ? abort_cyc - 5 : 0;
    else if (init_cyc > 0) nexp = (init_cyc > 5) ? init_cyc - 5 : 0;
    else                   nexp = p + MSG_LEN;
    chk({tag, " nwrites"}, 64'(nwr), 64'(nexp));
    if (!stopped) chk({tag, " nloads"}, 64'(nload), 64'd1);
    build_expect(p, taps_raw[5:0], seed, nexp);
    for (int a = OUT_BASE; a < 128; a++)
      chk($sformatf("%s mem[%0d]", tag, a), {56'b0, out_mem[a]}, {56'b0, exp_mem[a]});
  endtask

  initial begin
    int p;
    init = 1'b1; go = 1'b0; abort = 1'b0; clr = 1'b0;
    for (int i = 0; i < 256; i++) src[i] = 8'h00;
    #3;
    chk("reset_outs", {mem_raddr, mem_we, mem_waddr, mem_wdata, lfsr_load, lfsr_en,
                       lfsr_taps, lfsr_start, busy, done}, 64'd0);
    @(negedge clk); init = 1'b0;

    run(8'd8, 8'h21, 8'h01, 0, 0, 0, "basic");
    run(8'd3, 8'h33, 8'h2A, 0, 0, 0, "clamp_lo");
    run(8'd20, 8'h2D, 8'h17, 0, 0, 0, "clamp_hi");
    run(8'd9, 8'h30, 8'h00, 0, 0, 0, "zero_seed");
    run(8'd8, 8'h21, 8'h05, 7 + 8, 0, 0, "abort_msg");
    run(8'd10, 8'h39, 8'h11, 0, 0, 0, "after_abort");
    run(8'd8, 8'h21, 8'h09, 0, 0, 7, "init_pre");
    run(8'd11, 8'h27, 8'h3C, 0, 10, 0, "go_busy");

    // abort beats go while idle
    @(negedge clk); go = 1'b1; abort = 1'b1;
    @(negedge clk); go = 1'b0; abort = 1'b0; #1;
    chk("abort_go_idle", {62'b0, busy, mem_we}, 64'd0);

    for (int r = 0; r < 4; r++) begin
      logic [7:0] pr;
      pr = 8'($urandom_range(0, 25));
      p  = (pr < 8'd7) ? 7 : ((pr > 8'd12) ? 12 : int'(pr));
      run(pr, 8'($urandom), 8'($urandom), 0, 0, 0, $sformatf("rand%0d", r));
      run(pr, 8'($urandom), 8'($urandom), int'($urandom_range(1, 4 + p + MSG_LEN)), 0, 0,
          $sformatf("rabort%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
